// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and types for the register-file write-back arbiter.
//   XLEN_DEF : default datapath width
//   REG_AW   : register address width
//   wb_req_t : buffered mul/div result (destination + data)
//   wb_src_e : write-port source selection
package wb_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_AW   = 5;

  typedef struct packed {
    logic [REG_AW-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_MD
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t with occupancy count.
// Ports:
//   clk, rst (sync, active-low)
//   push, push_data : write one entry (caller guarantees not full)
//   pop             : drop the head entry (caller guarantees not empty)
//   head            : current head entry
//   count, full, empty : occupancy status
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_data,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; stale entries are unreachable after pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the MEM/WB pipeline result and the mul/div result stream
// onto the single register-file write port, with a pending-result scoreboard.
// Optional macro WB_BYPASS_EN adds combinational read bypass ports.
// Ports:
//   clk, rst (sync, active-low)
//   pipe_valid/pipe_rd/pipe_data : non-stallable pipeline result
//   md_valid/md_rd/md_data/md_ready : mul/div result handshake
//   issue_valid/issue_rd : mul/div op launched by decode
//   we/waddr/wd : registered register-file write
//   pending : per-register "awaiting mul/div result" flags
//   md_count : result FIFO occupancy
//   [WB_BYPASS_EN] rd_addr1/2, rf_data1/2 in; byp_data1/2 out
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MD_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_valid,
  input  logic [4:0]                pipe_rd,
  input  logic [XLEN-1:0]           pipe_data,
  input  logic                      md_valid,
  input  logic [4:0]                md_rd,
  input  logic [XLEN-1:0]           md_data,
  output logic                      md_ready,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd,
  output logic                      we,
  output logic [4:0]                waddr,
  output logic [XLEN-1:0]           wd,
  output logic [31:0]               pending,
  output logic [$clog2(MD_DEPTH):0] md_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]                rd_addr1,
  input  logic [4:0]                rd_addr2,
  input  logic [XLEN-1:0]           rf_data1,
  input  logic [XLEN-1:0]           rf_data2,
  output logic [XLEN-1:0]           byp_data1,
  output logic [XLEN-1:0]           byp_data2
`endif
);

  wb_req_t  fifo_in;
  wb_req_t  fifo_head;
  logic     fifo_push;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;
  wb_src_e  src;
  logic [31:0] pending_nxt;

  // Mul/div result buffer.
  assign fifo_in   = '{rd: md_rd, data: XLEN_DEF'(md_data)};
  assign md_ready  = rst && !fifo_full;
  assign fifo_push = md_valid && md_ready;

  wb_fifo #(
    .DEPTH (MD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (md_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Source selection: pipeline has priority; an x0 pipeline result frees the slot.
  always_comb begin
    src = WB_NONE;
    if (pipe_valid && (pipe_rd != 5'd0)) src = WB_PIPE;
    else if (!fifo_empty)                src = WB_MD;
  end

  assign fifo_pop = (src == WB_MD);

  // Write-port output registers; an x0 FIFO head is consumed without a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wd    <= '0;
    end else begin
      unique case (src)
        WB_PIPE: begin
          we    <= 1'b1;
          waddr <= pipe_rd;
          wd    <= pipe_data;
        end
        WB_MD: begin
          we <= (fifo_head.rd != 5'd0);
          if (fifo_head.rd != 5'd0) begin
            waddr <= fifo_head.rd;
            wd    <= XLEN'(fifo_head.data);
          end
        end
        default: we <= 1'b0;
      endcase
    end
  end

  // Scoreboard next state: clear on a real mul/div write, then set (set wins).
  always_comb begin
    pending_nxt = pending;
    if ((src == WB_MD) && (fifo_head.rd != 5'd0)) pending_nxt[fifo_head.rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0))        pending_nxt[issue_rd]     = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

`ifdef WB_BYPASS_EN
  // Forward the value being written this cycle to decode's read ports.
  assign byp_data1 = (we && (waddr == rd_addr1) && (waddr != 5'd0)) ? wd : rf_data1;
  assign byp_data2 = (we && (waddr == rd_addr2) && (waddr != 5'd0)) ? wd : rf_data2;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench for wb_arbiter with an in-order write scoreboard.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wd;
  logic [31:0] pending;
  logic [1:0]  md_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rf_data1, rf_data2, byp_data1, byp_data2;
`endif

  int checks = 0;
  int errors = 0;
  wb_req_t exp_q[$];

  wb_arbiter #(.XLEN(32), .MD_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_valid  (pipe_valid),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .md_valid    (md_valid),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .md_ready    (md_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we          (we),
    .waddr       (waddr),
    .wd          (wd),
    .pending     (pending),
    .md_count    (md_count)
`ifdef WB_BYPASS_EN
    ,
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rf_data1    (rf_data1),
    .rf_data2    (rf_data2),
    .byp_data1   (byp_data1),
    .byp_data2   (byp_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wb_req_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one clock; every observed write is checked against the scoreboard.
  task automatic step();
    wb_req_t e;
    @(posedge clk);
    #1;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 64'(we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_waddr", 64'(waddr), 64'(e.rd));
        chk("sb_wd", 64'(wd), 64'(e.data));
      end
    end
  endtask

  task automatic idle();
    pipe_valid  = 1'b0;
    md_valid    = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1;
    md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h2;
    issue_valid = 1'b1; issue_rd = 5'd3;
`ifdef WB_BYPASS_EN
    rd_addr1 = '0; rd_addr2 = '0; rf_data1 = '0; rf_data2 = '0;
`endif

    // Reset with all inputs active
    step(); step();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_md_count", 64'(md_count), 64'd0);
    chk("rst_md_ready", 64'(md_ready), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wd", 64'(wd), 64'd0);
    rst = 1'b1;
    idle();
    step();
    chk("post_rst_md_ready", 64'(md_ready), 64'd1);
    chk("post_rst_we", 64'(we), 64'd0);
    chk("post_rst_md_count", 64'(md_count), 64'd0);

    // Pipeline write: visible the following cycle
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    chk("pipe_we", 64'(we), 64'd1);
    pipe_valid = 1'b0;
    step();
    chk("pipe_idle_we", 64'(we), 64'd0);
    chk("pipe_idle_waddr_hold", 64'(waddr), 64'd5);

    // Pipeline priority over a buffered mul/div result
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    chk("pending_set7", 64'(pending), 64'h80);
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA0;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h11;
    expect_wr(5'd3, 32'hA0);
    step();
    md_valid = 1'b0;
    chk("prio_md_count", 64'(md_count), 64'd1);
    pipe_data = 32'hA1; expect_wr(5'd3, 32'hA1);
    step();
    pipe_data = 32'hA2; expect_wr(5'd3, 32'hA2);
    step();
    chk("prio_pending_held", 64'(pending), 64'h80);
    chk("prio_md_count_held", 64'(md_count), 64'd1);
    pipe_valid = 1'b0;
    expect_wr(5'd7, 32'h11);
    step();
    chk("prio_md_we", 64'(we), 64'd1);
    chk("prio_md_waddr", 64'(waddr), 64'd7);
    chk("prio_pending_clr", 64'(pending), 64'd0);
    chk("prio_md_count_empty", 64'(md_count), 64'd0);

    // Back-pressure: pipeline busy while three results arrive
    pipe_valid = 1'b1; pipe_rd = 5'd10; pipe_data = 32'hB0;
    md_valid = 1'b1; md_rd = 5'd12; md_data = 32'hC0;
    expect_wr(5'd10, 32'hB0);
    step();
    md_rd = 5'd13; md_data = 32'hC1; pipe_data = 32'hB1;
    expect_wr(5'd10, 32'hB1);
    step();
    chk("bp_full_ready", 64'(md_ready), 64'd0);
    chk("bp_full_count", 64'(md_count), 64'd2);
    md_rd = 5'd14; md_data = 32'hC2; pipe_data = 32'hB2;
    expect_wr(5'd10, 32'hB2);
    step();
    chk("bp_starved_ready", 64'(md_ready), 64'd0);
    chk("bp_starved_count", 64'(md_count), 64'd2);
    pipe_valid = 1'b0;
    expect_wr(5'd12, 32'hC0);
    step();
    chk("bp_after_pop_ready", 64'(md_ready), 64'd1);
    chk("bp_after_pop_count", 64'(md_count), 64'd1);
    expect_wr(5'd13, 32'hC1);
    step();
    chk("bp_push_pop_count", 64'(md_count), 64'd1);
    md_valid = 1'b0;
    expect_wr(5'd14, 32'hC2);
    step();
    chk("bp_drain_count", 64'(md_count), 64'd0);
    step();
    chk("bp_idle_we", 64'(we), 64'd0);

    // x0 handling and set-wins scoreboard
    issue_valid = 1'b1; issue_rd = 5'd9;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    step();
    issue_valid = 1'b0;
    chk("x0_setup_we", 64'(we), 64'd0);
    chk("x0_pending9", 64'(pending), 64'h200);
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
    md_rd = 5'd0; md_data = 32'h77;
    issue_valid = 1'b1; issue_rd = 5'd9;
    expect_wr(5'd9, 32'h99);
    step();
    chk("x0_pipe_drop_we", 64'(we), 64'd1);
    chk("x0_pipe_drop_waddr", 64'(waddr), 64'd9);
    chk("x0_set_wins", 64'(pending), 64'h200);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    issue_valid = 1'b0;
    chk("x0_head_we", 64'(we), 64'd0);
    chk("x0_head_waddr_hold", 64'(waddr), 64'd9);
    chk("x0_head_count", 64'(md_count), 64'd0);
    chk("x0_issue_ignored", 64'(pending), 64'h200);

`ifdef WB_BYPASS_EN
    // Read bypass of the in-flight write
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h55;
    expect_wr(5'd4, 32'h55);
    step();
    pipe_valid = 1'b0;
    rd_addr1 = 5'd4; rf_data1 = 32'h0;
    rd_addr2 = 5'd6; rf_data2 = 32'h66;
    #1;
    chk("byp1_hit", 64'(byp_data1), 64'h55);
    chk("byp2_miss", 64'(byp_data2), 64'h66);
    rd_addr1 = 5'd0; rf_data1 = 32'h1234;
    #1;
    chk("byp1_x0", 64'(byp_data1), 64'h1234);
    step();
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the decode-stage register file's single write port. It merges two result producers into one registered stream of `we`/`waddr`/`wd` writes, one per cycle:
- the in-order MEM/WB pipeline path, which cannot stall;
- the multi-cycle mul/div unit, which uses a valid/ready handshake.

It buffers mul/div results while the pipeline path owns the port, discards writes to x0, and keeps a per-register pending scoreboard for the hazard unit.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `MD_DEPTH`, 2: mul/div result FIFO depth; a power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `rst`, in, 1: synchronous, active-low reset.
- `pipe_valid`, in, 1: MEM/WB result present this cycle.
- `pipe_rd`, in, 5: destination register of the pipeline result.
- `pipe_data`, in, XLEN: pipeline result.
- `md_valid`, in, 1: mul/div result offered.
- `md_rd`, in, 5: mul/div destination register.
- `md_data`, in, XLEN: mul/div result.
- `md_ready`, out, 1: FIFO can accept a result.
- `issue_valid`, in, 1: decode launched a mul/div op this cycle.
- `issue_rd`, in, 5: destination register of the launched op.
- `we`, out, 1: register-file write enable (registered).
- `waddr`, out, 5: register-file write address (registered).
- `wd`, out, XLEN: register-file write data (registered).
- `pending`, out, 32: bit i = register i awaits a mul/div result.
- `md_count`, out, $clog2(MD_DEPTH)+1: FIFO occupancy.

## Operation
- **Result FIFO**
  - A mul/div result is accepted when `md_valid && md_ready`.
  - `md_ready = (md_count != MD_DEPTH)`. It is combinational from state only, not from `md_valid`.
  - Read and write pointers are $clog2(MD_DEPTH) bits and wrap modulo MD_DEPTH.
  - Push and pop in the same cycle leave the count unchanged. Push while full is impossible by handshake.
- **Port selection each cycle (priority order)**
  1. `pipe_valid && pipe_rd != 0`: pipeline result drives the port.
  2. Otherwise, if FIFO is non-empty: pop the head and drive it.
  3. Otherwise: no write.
- **x0 handling**
  - A pipeline result with rd=0 is dropped, and a FIFO pop may use that cycle.
  - A FIFO head with rd=0 is popped with `we`=0 for that cycle.
- **Registered output**
  - The winner is latched into `we`/`waddr`/`wd` at the next posedge.
  - With no winner, `we`=0. `waddr`/`wd` hold their last values.
- **Scoreboard `pending`**
  - Set bit `issue_rd` on `issue_valid` (ignored for rd=0).
  - Clear bit `waddr` on the edge where a popped FIFO entry is latched into the output with rd≠0.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.
- **Reset**
  - `rst`=0 at a posedge clears FIFO pointers and count, `pending`, and `we`/`waddr`/`wd` to 0.
  - Contents of an in-flight FIFO are discarded.
  - While `rst`=0, `md_ready`=0.

## Timing
- Pipeline result offered in cycle N → `we`=1 during cycle N+1. The register file commits at the end of N+1.
- Mul/div push at the edge ending cycle N → earliest pop in N+1 → `we` in N+2. There is no same-cycle FIFO bypass.
- Sustained pipeline traffic starves the FIFO. This is legal: the producer back-pressures through `md_ready`.
- `pending` bit reflects an issue from the edge after `issue_valid`. It clears on the same edge `we` rises for that write.
- Reset values: `we`=0, `waddr`=0, `wd`=0, `md_ready`=0 during reset and `md_ready`=1 after, `pending`=0, `md_count`=0.

## Configuration
- Macro: `WB_BYPASS_EN`.
- **Defined**: adds the following ports, driven combinationally.
  - Inputs: `rd_addr1`, `rd_addr2` (5), `rf_data1`, `rf_data2` (XLEN).
  - Outputs: `byp_data1`, `byp_data2` (XLEN).
  - Behaviour: `byp_dataK = (we && waddr == rd_addrK && waddr != 0) ? wd : rf_dataK`. This gives decode the value being written this cycle.
- **Undefined**: these ports are absent. Decode stalls one cycle on a write/read address match instead.

## Structure
- Package `wb_pkg`:
  - `XLEN_DEF` = 32.
  - `REG_AW` = 5.
  - `typedef struct packed {logic [4:0] rd; logic [XLEN-1:0] data;} wb_req_t`.
  - `typedef enum logic [1:0] {WB_NONE, WB_PIPE, WB_MD} wb_src_e`, used for the selection mux.
- Sub-module `wb_fifo`:
  - Parameterised synchronous FIFO of `wb_req_t`.
  - Outputs `count`, `full`, `empty`.
  - Holds the pointers and storage.
- `wb_arbiter` holds:
  - the selection logic;
  - the output registers;
  - the scoreboard;
  - the optional bypass.

## Test plan
- **Reset**: hold `rst`=0 for 2 cycles with all inputs active → `we`=0, `pending`=0, `md_count`=0, `md_ready`=0; `md_ready`=1 one cycle after release.
- **Pipeline write**: `pipe_valid`=1, rd=5, data=0xDEADBEEF in cycle N → `we`=1, `waddr`=5, `wd`=0xDEADBEEF in N+1.
- **Pipeline priority**:
  - Setup: FIFO holds {rd=7, 0x11}; pipeline writes rd=3 for 3 cycles, then idles.
  - Expect: three rd=3 writes, then rd=7 on the next cycle.
  - Expect: `pending[7]` (set by a prior issue) clears on that same edge.
- **Back-pressure**:
  - Setup: MD_DEPTH=2; push 3 mul/div results while pipeline is continuously busy.
  - Expect: `md_ready`=0 after 2 pushes; the third is accepted only after the first pop; order is preserved.
- **x0 drop**: pipeline rd=0 with FIFO head rd=9 in the same cycle → next cycle `we`=1, `waddr`=9; a FIFO head with rd=0 pops with `we`=0.
- **Bypass** (`WB_BYPASS_EN`): `we`=1, `waddr`=4, `wd`=0x55, `rd_addr1`=4, `rf_data1`=0x0 → `byp_data1`=0x55; with `rd_addr1`=0, `byp_data1`=`rf_data1`.
